// File: rtl/spmmio_pkg.sv
// Shared types and constants for the service-processor MMIO fabric.
// Also provides the status-slot word packing used by the fabric.
package spmmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } spmmio_state_e;

    localparam int SPMMIO_SLOT_W = 8;
    localparam logic [SPMMIO_SLOT_W-1:0] SPMMIO_STATUS_SLOT = 8'hFF;
    localparam logic [31:0] SPMMIO_ERR_DATA = 32'hFFFF_FFFF;

    function automatic logic [31:0] spmmio_status_word(
        input logic [15:0]              timeouts,
        input logic [SPMMIO_SLOT_W-1:0] last_slot,
        input logic                     unmapped,
        input logic                     timed_out
    );
        return {timeouts, last_slot, 6'b00_0000, unmapped, timed_out};
    endfunction

endpackage

// File: rtl/spmmio_watchdog.sv
// Wait-cycle counter for slave-acknowledged slots; flags when the next
// counted cycle would reach the configured limit.
module spmmio_watchdog (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        run,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count_r;

    // Wait counter: cleared outside WAIT, saturating increment while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 16'd0;
        end else if (clear) begin
            count_r <= 16'd0;
        end else if (run && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (({1'b0, count_r} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/spmmio_fabric.sv
// Service-processor MMIO fabric: decodes adr_i[0:7] to a peripheral slot,
// waits for decoder or peripheral acknowledge, and keeps error status.
module spmmio_fabric
    import spmmio_pkg::*;
#(
    parameter int          NUM_SLOTS      = 8,
    parameter logic [15:0] SLAVE_ACK_MASK = 16'h0008,
    parameter int          TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [0:23]               adr_i,
    input  logic                      stb_i,
    input  logic                      cyc_i,
    input  logic                      we_i,
    input  logic [0:3]                sel_i,
    input  logic [0:31]               dat_i,
    output logic                      ack_o,
    output logic [0:31]               dat_o,
    output logic                      err_o,
    output logic [0:NUM_SLOTS-1]      slot_cs_o,
    input  logic [0:32*NUM_SLOTS-1]   slot_dat_i,
    input  logic [0:NUM_SLOTS-1]      slot_ack_i
);

    localparam logic [SPMMIO_SLOT_W-1:0] NUM_SLOTS_W = SPMMIO_SLOT_W'(NUM_SLOTS);

    spmmio_state_e              state_r;
    logic [SPMMIO_SLOT_W-1:0]   slot_r;
    logic                       ack_r;
    logic                       err_r;
    logic [0:31]                dat_r;
    logic [15:0]                timeouts_r;
    logic [SPMMIO_SLOT_W-1:0]   last_err_slot_r;
    logic                       sticky_unmapped_r;
    logic                       sticky_timeout_r;

    logic [SPMMIO_SLOT_W-1:0]   idx_s;
    logic [SPMMIO_SLOT_W-1:0]   cur_slot_s;
    logic                       mapped_s;
    logic                       cs_en_s;
    logic [0:31]                sel_dat_s;
    logic                       sel_ack_s;
    logic                       sel_slave_s;
    logic                       expired_s;
    logic                       unused_s;

    assign idx_s      = adr_i[0:7];
    assign mapped_s   = (idx_s < NUM_SLOTS_W);
    // Once in WAIT the latched slot governs, whatever the address does now.
    assign cur_slot_s = (state_r == ST_WAIT) ? slot_r : idx_s;
    assign cs_en_s    = !reset &&
                        (((state_r == ST_IDLE) && cyc_i && stb_i && mapped_s) ||
                         ((state_r == ST_WAIT) && cyc_i));
    assign unused_s   = ^{adr_i[8:23], sel_i, dat_i};

    // Slot select: chip selects plus the addressed slot's data, ack and mask bit.
    always_comb begin
        slot_cs_o   = '0;
        sel_dat_s   = 32'h0000_0000;
        sel_ack_s   = 1'b0;
        sel_slave_s = 1'b0;
        for (int n = 0; n < NUM_SLOTS; n++) begin
            slot_cs_o[n] = cs_en_s && (cur_slot_s == SPMMIO_SLOT_W'(n));
            sel_dat_s    = sel_dat_s |
                           ({32{cur_slot_s == SPMMIO_SLOT_W'(n)}} & slot_dat_i[32*n +: 32]);
            sel_ack_s    = sel_ack_s | (slot_ack_i[n] && (cur_slot_s == SPMMIO_SLOT_W'(n)));
            sel_slave_s  = sel_slave_s | (SLAVE_ACK_MASK[n] && (cur_slot_s == SPMMIO_SLOT_W'(n)));
        end
    end

    spmmio_watchdog u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_r == ST_IDLE),
        .run     (state_r == ST_WAIT),
        .limit   (16'(TIMEOUT)),
        .expired (expired_s)
    );

    // Transaction FSM with registered response and status bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            slot_r            <= '0;
            ack_r             <= 1'b0;
            err_r             <= 1'b0;
            dat_r             <= 32'h0000_0000;
            timeouts_r        <= 16'd0;
            last_err_slot_r   <= '0;
            sticky_unmapped_r <= 1'b0;
            sticky_timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= 1'b0;
                    err_r <= 1'b0;
                    if (cyc_i && stb_i) begin
                        slot_r <= idx_s;
                        if (mapped_s) begin
                            if (!sel_slave_s || sel_ack_s) begin
                                dat_r   <= sel_dat_s;
                                ack_r   <= 1'b1;
                                state_r <= ST_RESP;
                            end else begin
                                state_r <= ST_WAIT;
                            end
                        end else if (idx_s == SPMMIO_STATUS_SLOT) begin
                            dat_r   <= spmmio_status_word(timeouts_r, last_err_slot_r,
                                                          sticky_unmapped_r, sticky_timeout_r);
                            ack_r   <= 1'b1;
                            state_r <= ST_RESP;
                            if (we_i) begin
                                timeouts_r        <= 16'd0;
                                last_err_slot_r   <= '0;
                                sticky_unmapped_r <= 1'b0;
                                sticky_timeout_r  <= 1'b0;
                            end
                        end else begin
                            dat_r             <= 32'h0000_0000;
                            sticky_unmapped_r <= 1'b1;
                            last_err_slot_r   <= idx_s;
                            ack_r             <= 1'b1;
                            state_r           <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!cyc_i) begin
                        state_r <= ST_IDLE;
                    end else if (sel_ack_s) begin
                        // A late ack still beats a same-cycle expiry.
                        dat_r   <= sel_dat_s;
                        ack_r   <= 1'b1;
                        state_r <= ST_RESP;
                    end else if (expired_s) begin
                        dat_r            <= SPMMIO_ERR_DATA;
                        ack_r            <= 1'b1;
                        err_r            <= 1'b1;
                        sticky_timeout_r <= 1'b1;
                        last_err_slot_r  <= slot_r;
                        timeouts_r       <= (timeouts_r == 16'hFFFF) ? timeouts_r
                                                                     : timeouts_r + 16'd1;
                        state_r          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o = ack_r;
    assign err_o = err_r;
    assign dat_o = dat_r;

endmodule

// File: tb/tb_spmmio_fabric.sv
// Randomized self-checking bench for spmmio_fabric against a transaction-level
// model of latency, data, error and status-slot behaviour.
module tb_spmmio_fabric;

    localparam int          NS   = 8;
    localparam int          TMO  = 255;
    localparam logic [15:0] MASK = 16'h0008;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [0:23]     adr_i = '0;
    logic            stb_i = 1'b0;
    logic            cyc_i = 1'b0;
    logic            we_i = 1'b0;
    logic [0:3]      sel_i = 4'hF;
    logic [0:31]     dat_i = '0;
    logic            ack_o;
    logic [0:31]     dat_o;
    logic            err_o;
    logic [0:NS-1]   slot_cs_o;
    logic [0:32*NS-1] slot_dat_i = '0;
    logic [0:NS-1]   slot_ack_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sd [NS];
    int          m_timeouts = 0;
    logic [7:0]  m_last = 8'h00;
    logic        m_unm = 1'b0;
    logic        m_tmo = 1'b0;

    spmmio_fabric #(.NUM_SLOTS(NS), .SLAVE_ACK_MASK(MASK), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .adr_i      (adr_i),
        .stb_i      (stb_i),
        .cyc_i      (cyc_i),
        .we_i       (we_i),
        .sel_i      (sel_i),
        .dat_i      (dat_i),
        .ack_o      (ack_o),
        .dat_o      (dat_o),
        .err_o      (err_o),
        .slot_cs_o  (slot_cs_o),
        .slot_dat_i (slot_dat_i),
        .slot_ack_i (slot_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [15:0] t;
        t = 16'(m_timeouts);
        return {t, m_last, 6'b000000, m_unm, m_tmo};
    endfunction

    task automatic load_slot_data();
        for (int n = 0; n < NS; n++) begin
            sd[n] = $urandom;
            slot_dat_i[32*n +: 32] = sd[n];
        end
    endtask

    // One access; ack_dly is the cycle the target slot acks (negative = never).
    task automatic do_access(input logic [7:0] slot, input logic we, input int ack_dly);
        int lat, cs_bad, ack_bad;
        logic [31:0] exp_dat;
        logic exp_err, mapped, slave, chk_dat;
        logic [0:NS-1] oh, exp_cs, noise;
        mapped  = (slot < 8'(NS));
        slave   = mapped && MASK[slot[3:0]];
        exp_err = 1'b0;
        chk_dat = 1'b1;
        lat     = 1;
        oh      = '0;
        if (mapped) oh[slot[2:0]] = 1'b1;
        if (mapped && !slave) begin
            exp_dat = sd[slot[2:0]];
        end else if (slave) begin
            if (ack_dly >= 0 && ack_dly <= TMO) begin
                lat = ack_dly + 1;
                exp_dat = sd[slot[2:0]];
            end else begin
                lat = TMO + 1;
                exp_dat = 32'hFFFF_FFFF;
                exp_err = 1'b1;
                if (m_timeouts < 65535) m_timeouts++;
                m_last = slot;
                m_tmo = 1'b1;
            end
        end else if (slot == 8'hFF) begin
            exp_dat = model_status();
            chk_dat = !we;
            if (we) begin
                m_timeouts = 0; m_last = 8'h00; m_unm = 1'b0; m_tmo = 1'b0;
            end
        end else begin
            exp_dat = 32'h0000_0000;
            m_unm = 1'b1;
            m_last = slot;
        end
        cs_bad = 0;
        ack_bad = 0;
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            adr_i = (c == 0) ? {slot, 16'($urandom)} : 24'($urandom);
            we_i  = (c == 0) ? we : 1'($urandom);
            cyc_i = (c <= lat);
            stb_i = (c == 0);
            noise = NS'($urandom);
            if (slave) noise[slot[2:0]] = (c == ack_dly);
            slot_ack_i = noise;
            #1;
            exp_cs = (c < lat) ? oh : '0;
            if (slot_cs_o !== exp_cs) cs_bad++;
            if (c < lat && ack_o !== 1'b0) ack_bad++;
            if (c == lat) begin
                check_eq("ack_at_latency", {31'd0, ack_o}, 32'd1);
                check_eq("err_flag", {31'd0, err_o}, {31'd0, exp_err});
                if (chk_dat) check_eq("read_data", dat_o, exp_dat);
            end
            if (c == lat + 1) check_eq("ack_single_cycle", {31'd0, ack_o}, 32'd0);
        end
        slot_ack_i = '0;
        check_eq("cs_trace", 32'(cs_bad), 32'd0);
        check_eq("no_early_ack", 32'(ack_bad), 32'd0);
    endtask

    initial begin
        int bad;
        for (int n = 0; n < NS; n++) sd[n] = 32'h0;
        #1;
        check_eq("reset_ack", {31'd0, ack_o}, 32'd0);
        check_eq("reset_err", {31'd0, err_o}, 32'd0);
        check_eq("reset_dat", dat_o, 32'd0);
        check_eq("reset_cs", 32'(slot_cs_o), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        load_slot_data();
        sd[0] = 32'h1234_5678; slot_dat_i[0 +: 32] = sd[0];
        do_access(8'h00, 1'b0, 0);
        sd[3] = 32'hCAFE_F00D; slot_dat_i[96 +: 32] = sd[3];
        do_access(8'h03, 1'b0, 5);
        do_access(8'h03, 1'b0, -1);
        do_access(8'hFF, 1'b0, 0);
        do_access(8'hFF, 1'b1, 0);
        do_access(8'h20, 1'b0, 0);
        do_access(8'hFF, 1'b0, 0);
        do_access(8'hFF, 1'b1, 0);
        do_access(8'hFF, 1'b0, 0);
        do_access(8'h03, 1'b0, TMO);
        do_access(8'h03, 1'b1, TMO + 1);
        do_access(8'h03, 1'b0, 0);

        // Held strobe on a decoder-ack slot: one access every two cycles.
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            adr_i = {8'h01, 16'h0000};
            cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
            #1;
            if (slot_cs_o !== ((c % 2 == 0) ? NS'(1 << (NS - 2)) : '0)) bad++;
            if (ack_o !== (c % 2 == 1)) bad++;
        end
        check_eq("held_strobe", 32'(bad), 32'd0);
        check_eq("held_strobe_dat", dat_o, sd[1]);
        @(negedge clk); cyc_i = 1'b0; stb_i = 1'b0;

        // Abort: cyc_i dropped in cycle 3 of a slot-3 wait.
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            adr_i = {8'h03, 16'h0000};
            cyc_i = (c < 3); stb_i = (c == 0);
            #1;
            if (c < 3 && slot_cs_o !== NS'(1 << (NS - 4))) bad++;
            if (c >= 4 && slot_cs_o !== '0) bad++;
            if (ack_o !== 1'b0) bad++;
        end
        check_eq("abort_no_ack", 32'(bad), 32'd0);
        do_access(8'hFF, 1'b0, 0);

        // Reset during WAIT.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            adr_i = {8'h03, 16'h0000};
            cyc_i = 1'b1; stb_i = (c == 0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_wait_cs", 32'(slot_cs_o), 32'd0);
        check_eq("rst_wait_ack", {31'd0, ack_o}, 32'd0);
        check_eq("rst_wait_err", {31'd0, err_o}, 32'd0);
        check_eq("rst_wait_dat", dat_o, 32'd0);
        @(negedge clk);
        reset = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        m_timeouts = 0; m_last = 8'h00; m_unm = 1'b0; m_tmo = 1'b0;
        do_access(8'h00, 1'b0, 0);
        do_access(8'hFF, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            int r;
            logic [7:0] s;
            load_slot_data();
            r = $urandom_range(0, 9);
            case (r)
                4:       s = 8'h03;
                5:       s = 8'hFF;
                6:       s = 8'($urandom_range(8, 254));
                7:       s = 8'h03;
                default: s = 8'($urandom_range(0, NS - 1));
            endcase
            do_access(s, 1'($urandom), (r == 7) ? $urandom_range(0, 300) : $urandom_range(0, 12));
        end
        do_access(8'hFF, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
